// File: rtl/interboard_rx_link.sv
// Receive side of the inter-board Request/Ack link: synchronises Request_in, acks each
// 6-bit word with a four-phase handshake and reassembles two-word frames into messages.
module interboard_rx_link #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [2:0]  RST_MSG_TYPE   = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_en,
    output logic [2:0] interboard_msg_type,
    output logic [4:0] interboard_number,
    output logic       interboard_rst,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT_W1
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;
    logic                 ack_q, ack_d;
    logic                 have_w0_q, have_w0_d;
    logic [2:0]           w0_type_q, w0_type_d;
    logic [1:0]           w0_nhi_q, w0_nhi_d;
    logic [2:0]           msg_type_q, msg_type_d;
    logic [4:0]           number_q, number_d;
    logic                 en_q, en_d;
    logic                 irst_q, irst_d;
    logic                 ferr_q, ferr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            have_w0_q  <= 1'b0;
            w0_type_q  <= '0;
            w0_nhi_q   <= '0;
            msg_type_q <= '0;
            number_q   <= '0;
            en_q       <= 1'b0;
            irst_q     <= 1'b0;
            ferr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], Request_in};
            state_q    <= state_d;
            ack_q      <= ack_d;
            have_w0_q  <= have_w0_d;
            w0_type_q  <= w0_type_d;
            w0_nhi_q   <= w0_nhi_d;
            msg_type_q <= msg_type_d;
            number_q   <= number_d;
            en_q       <= en_d;
            irst_q     <= irst_d;
            ferr_q     <= ferr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        have_w0_d  = have_w0_q;
        w0_type_d  = w0_type_q;
        w0_nhi_d   = w0_nhi_q;
        msg_type_d = msg_type_q;
        number_d   = number_q;
        en_d       = 1'b0;
        irst_d     = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (!inter_data_in[5]) begin
                        w0_type_d = inter_data_in[4:2];
                        w0_nhi_d  = inter_data_in[1:0];
                        have_w0_d = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                        have_w0_d = 1'b0;
                    end
                end
            end
            S_WAIT_W1: begin
                if (req_s) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (inter_data_in[5]) begin
                        msg_type_d = w0_type_q;
                        number_d   = {w0_nhi_q, inter_data_in[2:0]};
                        en_d       = 1'b1;
                        irst_d     = (w0_type_q == RST_MSG_TYPE);
                        have_w0_d  = 1'b0;
                    end else begin
                        // a fresh word0 here restarts the frame rather than being dropped
                        ferr_d    = 1'b1;
                        w0_type_d = inter_data_in[4:2];
                        w0_nhi_d  = inter_data_in[1:0];
                        have_w0_d = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    ferr_d    = 1'b1;
                    have_w0_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = have_w0_q ? S_WAIT_W1 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = (state_q == S_WAIT_W1 && state_d == S_WAIT_W1) ? cnt_q + 1'b1 : '0;
    end

    assign Ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign interboard_msg_type = msg_type_q;
    assign interboard_number   = number_q;
    assign interboard_rst      = irst_q;
    assign frame_err           = ferr_q;
    assign busy                = (state_q != S_IDLE) | ack_q;

endmodule

// File: tb/tb_interboard_rx_link.sv
// Bench for interboard_rx_link: table of two-word frames plus hand-written error,
// timeout and reset sequences, with decoded messages checked against an expectation queue.
module tb_interboard_rx_link;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out, interboard_en, interboard_rst, frame_err, busy;
    logic [2:0] interboard_msg_type;
    logic [4:0] interboard_number;

    always #5 clk = ~clk;

    interboard_rx_link #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(100),
        .RST_MSG_TYPE  (3'd7)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .Request_in         (Request_in),
        .inter_data_in      (inter_data_in),
        .Ack_out            (Ack_out),
        .interboard_en      (interboard_en),
        .interboard_msg_type(interboard_msg_type),
        .interboard_number  (interboard_number),
        .interboard_rst     (interboard_rst),
        .frame_err          (frame_err),
        .busy               (busy)
    );

    typedef struct packed {
        logic [2:0] t;
        logic [4:0] n;
        logic       r;
    } msg_t;

    typedef struct {
        logic [5:0] w0;
        logic [5:0] w1;
        int         t;
        int         n;
        int         r;
    } vec_t;

    msg_t exp_q[$];
    msg_t obs[0:63];
    int   n_obs = 0;
    int   ferr_cnt = 0;
    int   viol = 0;
    logic prev_en = 1'b0, prev_ferr = 1'b0, prev_irst = 1'b0;

    int total = 0;
    int bad = 0;
    int rd = 0;
    int exp_ferr = 0;

    always @(negedge clk) begin
        if (interboard_en && n_obs < 64) begin
            obs[n_obs] = '{interboard_msg_type, interboard_number, interboard_rst};
            n_obs++;
        end
        if (frame_err) ferr_cnt++;
        if ((interboard_en && prev_en) || (frame_err && prev_ferr) ||
            (interboard_rst && prev_irst) || (interboard_rst && !interboard_en))
            viol++;
        prev_en   = interboard_en;
        prev_ferr = frame_err;
        prev_irst = interboard_rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        msg_t m;
        repeat (4) @(negedge clk);
        chk({name, " msgcount"}, n_obs - rd, exp_q.size());
        while (rd < n_obs && exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk({name, " msg_type"}, int'(obs[rd].t), int'(m.t));
            chk({name, " number"},   int'(obs[rd].n), int'(m.n));
            chk({name, " rst"},      int'(obs[rd].r), int'(m.r));
            rd++;
        end
        rd = n_obs;
        exp_q.delete();
        chk({name, " frame_err count"}, ferr_cnt, exp_ferr);
    endtask

    task automatic send_word(input logic [5:0] d, input string name);
        int n;
        @(negedge clk);
        inter_data_in = d;
        Request_in    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Ack_out && n < 50);
        chk({name, " ack rise latency"}, n, 3);
        Request_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Ack_out && n < 50);
        chk({name, " ack fall latency"}, n, 3);
    endtask

    task automatic push_msg(input int t, input int n, input int r);
        msg_t m;
        m.t = 3'(t);
        m.n = 5'(n);
        m.r = 1'(r);
        exp_q.push_back(m);
    endtask

    vec_t vecs[5];

    initial begin
        int n;

        vecs[0] = '{6'b0_011_10, 6'b1_00_101, 3, 21, 0};
        vecs[1] = '{6'b0_111_00, 6'b1_00_000, 7, 0, 1};
        vecs[2] = '{6'b0_010_01, 6'b1_11_001, 2, 9, 0};
        vecs[3] = '{6'b0_000_11, 6'b1_11_111, 0, 31, 0};
        vecs[4] = '{6'b0_101_10, 6'b1_01_000, 5, 16, 0};

        rst = 1'b0;
        Request_in = 1'b0;
        inter_data_in = '0;
        repeat (3) @(negedge clk);
        chk("reset Ack_out", int'(Ack_out), 0);
        chk("reset en", int'(interboard_en), 0);
        chk("reset msg_type", int'(interboard_msg_type), 0);
        chk("reset number", int'(interboard_number), 0);
        chk("reset irst", int'(interboard_rst), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            push_msg(vecs[i].t, vecs[i].n, vecs[i].r);
            send_word(vecs[i].w0, $sformatf("vec%0d w0", i));
            send_word(vecs[i].w1, $sformatf("vec%0d w1", i));
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d held type", i), int'(interboard_msg_type), vecs[i].t);
            chk($sformatf("vec%0d busy idle", i), int'(busy), 0);
        end

        // stray word1 while expecting word0
        exp_ferr++;
        send_word(6'b100011, "stray w1");
        push_msg(2, 9, 0);
        send_word(6'b0_010_01, "after stray w0");
        send_word(6'b1_00_001, "after stray w1");
        drain("stray");

        // second word0 replaces the first
        exp_ferr++;
        push_msg(4, 10, 0);
        send_word(6'b0_001_00, "resync w0a");
        send_word(6'b0_100_01, "resync w0b");
        send_word(6'b1_00_010, "resync w1");
        drain("resync");

        // timeout after word0
        send_word(6'b0_011_01, "tmo w0");
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 50) chk("tmo busy mid", int'(busy), 1);
        end while (!frame_err && n < 200);
        chk("tmo cycles", n, 100);
        chk("tmo busy after", int'(busy), 0);
        exp_ferr++;
        exp_ferr++;
        send_word(6'b1_00_101, "tmo late w1");
        drain("timeout");

        // reset while Ack_out is high on word1 (message already emitted on Ack rise)
        push_msg(6, 3, 0);
        send_word(6'b0_110_00, "rstA w0");
        @(negedge clk);
        inter_data_in = 6'b1_00_011;
        Request_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!Ack_out && n < 50);
        chk("rstA ack seen", int'(Ack_out), 1);
        #1 rst = 1'b0;
        #1;
        chk("rstA Ack_out async", int'(Ack_out), 0);
        chk("rstA busy", int'(busy), 0);
        chk("rstA number", int'(interboard_number), 0);
        Request_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain("rstA");

        // reset before word1 is acked: frame lost, no message
        send_word(6'b0_001_11, "rstB w0");
        @(negedge clk);
        inter_data_in = 6'b1_00_111;
        Request_in = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rstB Ack_out", int'(Ack_out), 0);
        Request_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain("rstB");

        push_msg(5, 16, 0);
        send_word(6'b0_101_10, "post w0");
        send_word(6'b1_00_000, "post w1");
        drain("post reset");

        chk("pulse width violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
